sum_accumulator: RTL and testbench

- Downstream consumer of the 4-bit adder stage: takes its modulo-16 sum stream and accumulates NUM_SAMPLES beats into a wider registered total.
- Uses valid/ready handshakes on input and output, has an explicit 3-state FSM, and raises a sticky overflow flag.
- Feeds a result-consumer or display stage.

---
 rtl/sum_accumulator_pkg.sv | 14 +
 rtl/sum_accumulator_acc_add_sat.sv | 25 ++
 rtl/sum_accumulator.sv | 118 +++++++++++
 tb/tb_sum_accumulator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and default widths.
package sum_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_DATA_W      = 4;
    localparam int DEF_ACC_W       = 8;
    localparam int DEF_NUM_SAMPLES = 4;

endpackage

// File: rtl/sum_accumulator_acc_add_sat.sv
// Combinational accumulator adder: acc + zext(addend) with carry-out.
// With ACCUM_SAT_EN defined the sum clamps to all-ones on carry; otherwise it wraps.
module acc_add_sat #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, addend};
        carry    = wide_sum[ACC_W];
`ifdef ACCUM_SAT_EN
        sum      = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
        sum      = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES input beats into one registered result with a sticky overflow flag.
// Optional saturation instead of wrap is selected by the ACCUM_SAT_EN macro (see acc_add_sat).
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int  DATA_W      = DEF_DATA_W,
    parameter int  ACC_W       = DEF_ACC_W,
    parameter int  NUM_SAMPLES = DEF_NUM_SAMPLES,
    localparam int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  sample_cnt
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt_inc;

    acc_add_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc_add_sat (
        .acc    (acc_q),
        .addend (in_data),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = ACC_W'(in_data);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (NUM_SAMPLES == 1) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_carry;
                    if (cnt_inc == CNT_W'(NUM_SAMPLES)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase

        // A clear beats any handshake in the same cycle; that beat is simply lost.
        if (sclr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result outputs read as zero outside DONE so partial sums never leak downstream.
    assign out_valid  = (state_q == ST_DONE);
    assign out_data   = out_valid ? acc_q : '0;
    assign out_ovf    = out_valid ? ovf_q : 1'b0;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: default instance plus an ACC_W=5 instance for overflow.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclr;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_ovf;
    logic [2:0] sample_cnt;

    logic [3:0] in5_data;
    logic       in5_valid;
    logic       in5_ready;
    logic [4:0] out5_data;
    logic       out5_valid;
    logic       out5_ready;
    logic       out5_ovf;
    logic [2:0] sample5_cnt;

    typedef struct {
        int data;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sum_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclr       (sclr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ovf    (out_ovf),
        .sample_cnt (sample_cnt)
    );

    sum_accumulator #(.ACC_W(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclr       (sclr),
        .in_data    (in5_data),
        .in_valid   (in5_valid),
        .in_ready   (in5_ready),
        .out_data   (out5_data),
        .out_valid  (out5_valid),
        .out_ready  (out5_ready),
        .out_ovf    (out5_ovf),
        .sample_cnt (sample5_cnt)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference sum of four beats at a given accumulator width.
    function automatic exp_t model_sum(input int b0, input int b1, input int b2, input int b3,
                                       input int accw);
        exp_t r;
        int   bs[4];
        int   lim;
        bs     = '{b0, b1, b2, b3};
        lim    = (1 << accw) - 1;
        r.data = 0;
        r.ovf  = 0;
        foreach (bs[i]) begin
            r.data += bs[i];
            if (r.data > lim) begin
                r.ovf = 1;
`ifdef ACCUM_SAT_EN
                r.data = lim;
`else
                r.data -= lim + 1;
`endif
            end
        end
        return r;
    endfunction

    // Output monitor: one line per completed result, compared against the queue head.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn result data=%0d ovf=%0d (exp data=%0d ovf=%0d)",
                         out_data, out_ovf, e.data, e.ovf);
                check_val("sb_data", int'(out_data), e.data);
                check_val("sb_ovf", int'(out_ovf), e.ovf);
            end
        end
    end

    initial begin
        int   vld[7];
        int   dat[7];
        exp_t e5;

        rst_n      = 1'b1;
        sclr       = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in5_data   = '0;
        in5_valid  = 1'b0;
        out5_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_data", int'(out_data), 0);
        check_val("rst_out_ovf", int'(out_ovf), 0);
        check_val("rst_sample_cnt", int'(sample_cnt), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", int'(in_ready), 1);

        // Basic: 9,13,7,2 back to back -> 31
        exp_q.push_back(model_sum(9, 13, 7, 2, 8));
        in_valid = 1'b1;
        dat[0:3] = '{9, 13, 7, 2};
        for (int i = 0; i < 4; i++) begin
            in_data = 4'(dat[i]);
            @(posedge clk); #1;
            if (i == 2) begin
                check_val("a_valid_early", int'(out_valid), 0);
                check_val("a_cnt3", int'(sample_cnt), 3);
            end
        end
        in_valid = 1'b0;
        check_val("a_valid", int'(out_valid), 1);
        check_val("a_data", int'(out_data), 31);
        check_val("a_ovf", int'(out_ovf), 0);
        check_val("a_cnt4", int'(sample_cnt), 4);
        @(posedge clk); #1;
        check_val("a_consumed", int'(out_valid), 0);

        // Overflow at ACC_W=5: 15,15,7,2
        e5 = model_sum(15, 15, 7, 2, 5);
        in5_valid = 1'b1;
        dat[0:3] = '{15, 15, 7, 2};
        for (int i = 0; i < 4; i++) begin
            in5_data = 4'(dat[i]);
            @(posedge clk); #1;
        end
        in5_valid = 1'b0;
        $display("txn acc5 result data=%0d ovf=%0d", out5_data, out5_ovf);
        check_val("w5_valid", int'(out5_valid), 1);
        check_val("w5_data", int'(out5_data), e5.data);
        check_val("w5_ovf", int'(out5_ovf), 1);
        @(posedge clk); #1;
        check_val("w5_ovf_cleared", int'(out5_ovf), 0);

        // Backpressure: 1,2,3,4 -> 10 held while out_ready=0 and in_valid stays high
        out_ready = 1'b0;
        exp_q.push_back(model_sum(1, 2, 3, 4, 8));
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 4'(i);
            @(posedge clk); #1;
        end
        in_data = 4'd5;
        for (int i = 0; i < 3; i++) begin
            check_val("bp_in_ready", int'(in_ready), 0);
            check_val("bp_data_stable", int'(out_data), 10);
            check_val("bp_cnt_hold", int'(sample_cnt), 4);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        exp_q.push_back(model_sum(5, 0, 0, 0, 8));
        @(posedge clk); #1;
        check_val("bp_idle_valid", int'(out_valid), 0);
        check_val("bp_idle_ready", int'(in_ready), 1);
        check_val("bp_idle_cnt", int'(sample_cnt), 0);
        @(posedge clk); #1;
        check_val("bp_next_accepted", int'(sample_cnt), 1);
        in_data = 4'd0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("bp2_valid", int'(out_valid), 1);
        @(posedge clk); #1;

        // in_valid gaps: 3,_,5,_,_,1,4 -> 13 (junk data on idle cycles)
        exp_q.push_back(model_sum(3, 5, 1, 4, 8));
        vld = '{1, 0, 1, 0, 0, 1, 1};
        dat = '{3, 15, 5, 15, 15, 1, 4};
        for (int i = 0; i < 7; i++) begin
            in_valid = vld[i][0];
            in_data  = 4'(dat[i]);
            if (i == 6) check_val("g_valid_early", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("g_valid", int'(out_valid), 1);
        check_val("g_data", int'(out_data), 13);
        @(posedge clk); #1;

        // sclr after 6,6 with a coincident valid beat, then 4 beats of 1 -> 4
        in_valid = 1'b1;
        in_data  = 4'd6;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_val("s_cnt2", int'(sample_cnt), 2);
        sclr    = 1'b1;
        in_data = 4'd9;
        @(posedge clk); #1;
        sclr = 1'b0;
        check_val("s_cnt_cleared", int'(sample_cnt), 0);
        check_val("s_valid_cleared", int'(out_valid), 0);
        exp_q.push_back(model_sum(1, 1, 1, 1, 8));
        in_data = 4'd1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("s_valid", int'(out_valid), 1);
        check_val("s_data", int'(out_data), 4);
        @(posedge clk); #1;

        // Asynchronous reset mid-accumulation, then 4 beats of 2 -> 8
        in_valid = 1'b1;
        in_data  = 4'd7;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("r_cnt_before", int'(sample_cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        check_val("r_cnt_async", int'(sample_cnt), 0);
        check_val("r_valid_async", int'(out_valid), 0);
        check_val("r_data_async", int'(out_data), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model_sum(2, 2, 2, 2, 8));
        in_valid = 1'b1;
        in_data  = 4'd2;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("r_valid", int'(out_valid), 1);
        check_val("r_data", int'(out_data), 8);
        @(posedge clk); #1;

        check_val("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
